// File: rtl/nes_rom_loader.sv
// iNES ROM loader: parses the 16-byte header from the iosys byte stream and writes PRG/CHR payload to SDRAM.
// Define NES_ROM_LOADER_NES20_EN to honour NES 2.0 mapper/size extensions (12-bit sizes).
module nes_rom_loader #(
  parameter int unsigned       ADDR_W   = 22,
  parameter logic [ADDR_W-1:0] PRG_BASE = 22'h000000,
  parameter logic [ADDR_W-1:0] CHR_BASE = 22'h200000
`ifdef NES_ROM_LOADER_NES20_EN
  , localparam int unsigned SIZE_W = 12
`else
  , localparam int unsigned SIZE_W = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic              mem_ack,
  output logic [11:0]       mapper,
  output logic [SIZE_W-1:0] prg_size,
  output logic [SIZE_W-1:0] chr_size,
  output logic              mirroring,
  output logic              battery,
  output logic              header_valid,
  output logic              loader_busy,
  output logic              loader_done,
  output logic [1:0]        error,
  output logic              overflow
);

  localparam int unsigned CNT_W     = SIZE_W + 14;
  localparam logic [1:0]  ERR_NONE  = 2'd0;
  localparam logic [1:0]  ERR_MAGIC = 2'd1;
  localparam logic [1:0]  ERR_PRG   = 2'd2;
  localparam logic [1:0]  ERR_TRUNC = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_TRN, S_PRG, S_CHR, S_DONE, S_ERR} state_t;

  state_t           state_q, state_d;
  logic             valid_q, loading_q;
  logic [3:0]       hdr_cnt;
  logic [8:0]       trn_cnt;
  logic [CNT_W-1:0] offset, ofs_inc;
  logic             trainer;
  logic             byte_acc, load_rise, load_fall;
  logic [7:0]       magic_byte;
  logic             magic_bad, size_bad, prg_last, chr_last;
  logic             hdr_take, trn_take, wr_issue, wr_drop, err_set;
  logic [1:0]       err_code;
`ifdef NES_ROM_LOADER_NES20_EN
  logic             nes2;
  localparam logic [CNT_W:0] ADDR_SPAN = (CNT_W+1)'(1) << ADDR_W;
`endif

  assign byte_acc  = rom_do_valid & ~valid_q;
  assign load_rise = rom_loading & ~loading_q;
  assign load_fall = ~rom_loading & loading_q;
  assign ofs_inc   = offset + CNT_W'(1);
  assign prg_last  = (ofs_inc == {prg_size, 14'd0});
  assign chr_last  = (ofs_inc == {1'b0, chr_size, 13'd0});

`ifdef NES_ROM_LOADER_NES20_EN
  assign size_bad = (prg_size == '0) ||
                    ({1'b0, prg_size, 14'd0} > ADDR_SPAN) ||
                    ({2'b0, chr_size, 13'd0} > ADDR_SPAN);
`else
  assign size_bad = (prg_size == '0);
`endif

  // Expected iNES magic for header bytes 0..3
  always_comb begin
    magic_byte = 8'h1A;
    case (hdr_cnt[1:0])
      2'd0:    magic_byte = 8'h4E;
      2'd1:    magic_byte = 8'h45;
      2'd2:    magic_byte = 8'h53;
      default: ;
    endcase
  end

  assign magic_bad = (hdr_cnt < 4'd4) && (rom_do != magic_byte);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; a new load restarts from any state, a dropped load aborts the payload phases
  always_comb begin
    state_d = state_q;
    if (load_rise) begin
      state_d = S_HDR;
    end else begin
      case (state_q)
        S_HDR: begin
          if (load_fall) state_d = S_ERR;
          else if (byte_acc) begin
            if (magic_bad)               state_d = S_ERR;
            else if (hdr_cnt == 4'd15) begin
              if (size_bad)              state_d = S_ERR;
              else if (trainer)          state_d = S_TRN;
              else                       state_d = S_PRG;
            end
          end
        end
        S_TRN: begin
          if (load_fall)                               state_d = S_ERR;
          else if (byte_acc && (trn_cnt == 9'd511))    state_d = S_PRG;
        end
        S_PRG: begin
          if (load_fall)                  state_d = S_ERR;
          else if (wr_issue && prg_last)  state_d = (chr_size == '0) ? S_DONE : S_CHR;
        end
        S_CHR: begin
          if (load_fall)                  state_d = S_ERR;
          else if (wr_issue && chr_last)  state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle control strobes for the datapath
  always_comb begin
    hdr_take = 1'b0;
    trn_take = 1'b0;
    wr_issue = 1'b0;
    wr_drop  = 1'b0;
    err_set  = 1'b0;
    err_code = ERR_NONE;
    if (!load_rise) begin
      case (state_q)
        S_HDR: begin
          if (load_fall) begin
            err_set  = 1'b1;
            err_code = ERR_TRUNC;
          end else if (byte_acc) begin
            hdr_take = 1'b1;
            if (magic_bad) begin
              err_set  = 1'b1;
              err_code = ERR_MAGIC;
            end else if ((hdr_cnt == 4'd15) && size_bad) begin
              err_set  = 1'b1;
              err_code = ERR_PRG;
            end
          end
        end
        S_TRN: begin
          if (load_fall) begin
            err_set  = 1'b1;
            err_code = ERR_TRUNC;
          end else begin
            trn_take = byte_acc;
          end
        end
        S_PRG, S_CHR: begin
          if (load_fall) begin
            err_set  = 1'b1;
            err_code = ERR_TRUNC;
          end else if (byte_acc) begin
            // An ack in the same cycle frees the port for the new byte
            if (mem_req && !mem_ack) wr_drop  = 1'b1;
            else                     wr_issue = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      loading_q    <= 1'b0;
      hdr_cnt      <= 4'd0;
      trn_cnt      <= 9'd0;
      offset       <= '0;
      trainer      <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= 8'd0;
      mapper       <= 12'd0;
      prg_size     <= '0;
      chr_size     <= '0;
      mirroring    <= 1'b0;
      battery      <= 1'b0;
      header_valid <= 1'b0;
      loader_busy  <= 1'b0;
      loader_done  <= 1'b0;
      error        <= ERR_NONE;
      overflow     <= 1'b0;
`ifdef NES_ROM_LOADER_NES20_EN
      nes2         <= 1'b0;
`endif
    end else begin
      valid_q   <= rom_do_valid;
      loading_q <= rom_loading;

      if (load_fall) loader_busy <= 1'b0;
      if (err_set)   error       <= err_code;
      if (wr_drop)   overflow    <= 1'b1;
      if (trn_take)  trn_cnt     <= trn_cnt + 9'd1;

      if (hdr_take) begin
        hdr_cnt <= hdr_cnt + 4'd1;
        case (hdr_cnt)
          4'd4: prg_size <= SIZE_W'(rom_do);
          4'd5: chr_size <= SIZE_W'(rom_do);
          4'd6: begin
            mirroring   <= rom_do[0];
            battery     <= rom_do[1];
            trainer     <= rom_do[2];
            mapper[3:0] <= rom_do[7:4];
          end
          4'd7: begin
            mapper[7:4]  <= rom_do[7:4];
            mapper[11:8] <= 4'd0;
`ifdef NES_ROM_LOADER_NES20_EN
            nes2         <= (rom_do[3:2] == 2'b10);
`endif
          end
`ifdef NES_ROM_LOADER_NES20_EN
          4'd8: if (nes2) mapper[11:8] <= rom_do[3:0];
          4'd9: if (nes2) begin
            prg_size[11:8] <= rom_do[3:0];
            chr_size[11:8] <= rom_do[7:4];
          end
`endif
          4'd15: header_valid <= 1'b1;
          default: ;
        endcase
      end

      // Write port: address/data hold while the request is outstanding
      if (wr_issue) begin
        mem_req  <= 1'b1;
        mem_din  <= rom_do;
        mem_addr <= ((state_q == S_CHR) ? CHR_BASE : PRG_BASE) + ADDR_W'(offset);
        offset   <= ((state_q == S_PRG) && prg_last) ? '0 : ofs_inc;
      end else if (mem_ack) begin
        mem_req  <= 1'b0;
      end

      if ((state_q == S_DONE) && !mem_req) loader_done <= 1'b1;

      if (load_rise) begin
        hdr_cnt      <= 4'd0;
        trn_cnt      <= 9'd0;
        offset       <= '0;
        header_valid <= 1'b0;
        loader_done  <= 1'b0;
        error        <= ERR_NONE;
        overflow     <= 1'b0;
        loader_busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nes_rom_loader.sv
// Directed bench for nes_rom_loader: header vector table plus hand-written load sequences
// against a byte-wide memory responder and an expected-write scoreboard.
module tb_nes_rom_loader;

  logic        clk = 1'b0;
  logic        reset, rom_loading, rom_do_valid, mem_req, mem_ack;
  logic        mirroring, battery, header_valid, loader_busy, loader_done, overflow;
  logic [7:0]  rom_do, mem_din, prg_size, chr_size;
  logic [21:0] mem_addr;
  logic [11:0] mapper;
  logic [1:0]  error;

  always #5 clk = ~clk;

  nes_rom_loader dut (
    .clk(clk), .reset(reset), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_ack(mem_ack), .mapper(mapper), .prg_size(prg_size),
    .chr_size(chr_size), .mirroring(mirroring), .battery(battery),
    .header_valid(header_valid), .loader_busy(loader_busy),
    .loader_done(loader_done), .error(error), .overflow(overflow)
  );

  typedef struct packed { logic [21:0] addr; logic [7:0] data; } wr_t;

  typedef struct {
    logic [0:15][7:0] hdr;
    logic [1:0]       err;
    logic             hv;
    logic [11:0]      map;
    logic [7:0]       prg;
    logic [7:0]       chr;
    logic             mir;
    logic             bat;
    logic [1:0]       err_fall;
  } hvec_t;

  wr_t   exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    writes = 0;
  int    bad    = 0;
  string first_bad = "";
  logic  ack_hold = 1'b0;

  // Memory responder and write monitor: one-cycle ack per request, compares each new request to the queue
  initial begin : mem_model
    logic        prev_req, prev_ack;
    logic [21:0] prev_addr;
    logic [7:0]  prev_din;
    wr_t         e;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; prev_din = '0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (!prev_req || prev_ack) begin
          writes++;
          if (exp_q.size() == 0) begin
            bad++;
            if (first_bad == "") first_bad = $sformatf("unexpected %06h/%02h", mem_addr, mem_din);
          end else begin
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_din !== e.data) begin
              bad++;
              if (first_bad == "")
                first_bad = $sformatf("got %06h/%02h want %06h/%02h", mem_addr, mem_din, e.addr, e.data);
            end
          end
        end else if (mem_addr !== prev_addr || mem_din !== prev_din) begin
          bad++;
          if (first_bad == "") first_bad = $sformatf("unstable %06h/%02h", mem_addr, mem_din);
        end
      end
      prev_req  = (mem_req === 1'b1);
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
      prev_din  = mem_din;
      mem_ack   = (mem_req === 1'b1) && !ack_hold;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    rom_do = b;
    rom_do_valid = 1'b1;
    @(negedge clk);
    rom_do_valid = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [0:15][7:0] h);
    for (int j = 0; j < 16; j++) send(h[j], 4);
  endtask

  task automatic start_load();
    @(negedge clk);
    rom_loading = 1'b1;
    tick(2);
  endtask

  task automatic end_load();
    @(negedge clk);
    rom_loading = 1'b0;
    tick(3);
  endtask

  task automatic expect_wr(input logic [21:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_stream(input string name, input int got_writes, input int want_writes);
    check({name, "_writes"}, got_writes, want_writes);
    check($sformatf("%s_stream(%s)", name, first_bad), bad, 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  function automatic hvec_t mkv(input logic [127:0] h, input logic [1:0] err, input logic hv,
                                input logic [11:0] map, input logic [7:0] prg, input logic [7:0] chr,
                                input logic mir, input logic bat, input logic [1:0] ef);
    hvec_t v;
    v.hdr = h; v.err = err; v.hv = hv; v.map = map; v.prg = prg; v.chr = chr;
    v.mir = mir; v.bat = bat; v.err_fall = ef;
    return v;
  endfunction

  hvec_t vecs[6];

  initial begin : main
    logic [0:15][7:0] hdr;
    logic [7:0]       d;
    int               w0;

    // Bad-magic rows keep the fields latched by the row before them
    vecs[0] = mkv(128'h4E45531A_02010100_00000000_00000000, 2'd0, 1'b1, 12'h000, 8'd2,  8'd1, 1'b1, 1'b0, 2'd3);
    vecs[1] = mkv(128'h4E45531B_02010100_00000000_00000000, 2'd1, 1'b0, 12'h000, 8'd2,  8'd1, 1'b1, 1'b0, 2'd1);
    vecs[2] = mkv(128'h0045531A_00000000_00000000_00000000, 2'd1, 1'b0, 12'h000, 8'd2,  8'd1, 1'b1, 1'b0, 2'd1);
    vecs[3] = mkv(128'h4E45531A_00030200_00000000_00000000, 2'd2, 1'b1, 12'h000, 8'd0,  8'd3, 1'b0, 1'b1, 2'd2);
    vecs[4] = mkv(128'h4E45531A_1000F3A0_0FFFFFFF_FFFFFFFF, 2'd0, 1'b1, 12'h0AF, 8'd16, 8'd0, 1'b1, 1'b1, 2'd3);
    vecs[5] = mkv(128'h4E45531A_01001400_00000000_00000000, 2'd0, 1'b1, 12'h001, 8'd1,  8'd0, 1'b0, 1'b0, 2'd3);

    reset = 1'b1; rom_loading = 1'b0; rom_do_valid = 1'b0; rom_do = 8'd0;
    tick(3);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_flags", {header_valid, loader_busy, loader_done, overflow, error}, 0);
    check("rst_fields", {mapper, prg_size, chr_size, mirroring, battery}, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 6; i++) begin
      w0 = writes;
      start_load();
      send_hdr(vecs[i].hdr);
      tick(4);
      check($sformatf("v%0d_error", i), error, vecs[i].err);
      check($sformatf("v%0d_header_valid", i), header_valid, vecs[i].hv);
      check($sformatf("v%0d_mapper", i), mapper, vecs[i].map);
      check($sformatf("v%0d_prg_size", i), prg_size, vecs[i].prg);
      check($sformatf("v%0d_chr_size", i), chr_size, vecs[i].chr);
      check($sformatf("v%0d_mirroring", i), mirroring, vecs[i].mir);
      check($sformatf("v%0d_battery", i), battery, vecs[i].bat);
      check($sformatf("v%0d_busy", i), loader_busy, 1);
      end_load();
      check($sformatf("v%0d_error_after_fall", i), error, vecs[i].err_fall);
      check($sformatf("v%0d_busy_after_fall", i), loader_busy, 0);
      check($sformatf("v%0d_done", i), loader_done, 0);
      check($sformatf("v%0d_writes", i), writes - w0, 0);
    end

    // Full load: trainer, one PRG bank, one CHR bank
    w0 = writes;
    start_load();
    hdr = 128'h4E45531A_01011400_00000000_00000000;
    send_hdr(hdr);
    for (int k = 0; k < 512; k++) send(8'(k), 2);
    check("trn_no_writes", writes - w0, 0);
    for (int k = 0; k < 16384; k++) begin
      d = 8'(k * 7 + 3);
      expect_wr(22'(k), d);
      send(d, 2);
    end
    for (int k = 0; k < 8192; k++) begin
      d = 8'(k * 13 + 5);
      expect_wr(22'h200000 + 22'(k), d);
      send(d, 2);
    end
    tick(6);
    check_stream("full", writes - w0, 24576);
    check("full_done", loader_done, 1);
    check("full_error", error, 0);
    check("full_mapper", mapper, 1);
    check("full_busy", loader_busy, 1);
    send(8'hEE, 4);
    tick(2);
    check("full_after_done_writes", writes - w0, 24576);
    end_load();
    check("full_busy_after_fall", loader_busy, 0);
    check("full_done_after_fall", loader_done, 1);
    check("full_error_after_fall", error, 0);

    // Load cut short after 100 PRG bytes
    w0 = writes;
    start_load();
    send_hdr(vecs[0].hdr);
    for (int k = 0; k < 100; k++) begin
      d = 8'(k + 40);
      expect_wr(22'(k), d);
      send(d, 4);
    end
    tick(3);
    end_load();
    check("trunc_error", error, 3);
    check("trunc_busy", loader_busy, 0);
    check("trunc_done", loader_done, 0);
    check("trunc_mem_req", mem_req, 0);
    check_stream("trunc", writes - w0, 100);

    // Ack withheld: bytes arriving during a pending write are dropped
    w0 = writes;
    start_load();
    hdr = 128'h4E45531A_01000000_00000000_00000000;
    send_hdr(hdr);
    for (int k = 0; k < 3; k++) begin
      expect_wr(22'(k), 8'(k + 8'h60));
      send(8'(k + 8'h60), 4);
    end
    tick(2);
    check("ovf_clear_before", overflow, 0);
    ack_hold = 1'b1;
    expect_wr(22'd3, 8'hA5);
    send(8'hA5, 4);
    for (int k = 0; k < 4; k++) send(8'(8'h10 + k), 4);
    tick(2);
    check("ovf_req_pending", mem_req, 1);
    check("ovf_addr_held", mem_addr, 3);
    check("ovf_set", overflow, 1);
    ack_hold = 1'b0;
    tick(4);
    expect_wr(22'd4, 8'h5A);
    send(8'h5A, 4);
    tick(4);
    check_stream("ovf", writes - w0, 5);
    check("ovf_sticky", overflow, 1);
    end_load();

    // Reset with a write outstanding, then a clean restart
    w0 = writes;
    start_load();
    send_hdr(hdr);
    ack_hold = 1'b1;
    expect_wr(22'd0, 8'h77);
    send(8'h77, 4);
    check("rst2_req_before", mem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    rom_loading = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_mem_req", mem_req, 0);
    check("rst2_flags", {header_valid, loader_busy, loader_done, overflow, error}, 0);
    check("rst2_fields", {mapper, prg_size, chr_size, mirroring, battery}, 0);
    @(negedge clk);
    reset = 1'b0;
    ack_hold = 1'b0;
    tick(2);
    start_load();
    hdr = 128'h4E45531A_01002100_00000000_00000000;
    send_hdr(hdr);
    expect_wr(22'd0, 8'h31);
    send(8'h31, 4);
    expect_wr(22'd1, 8'h32);
    send(8'h32, 4);
    tick(4);
    check("restart_header_valid", header_valid, 1);
    check("restart_mapper", mapper, 2);
    check("restart_mirroring", mirroring, 1);
    check("restart_busy", loader_busy, 1);
    check("restart_error", error, 0);
    check_stream("restart", writes - w0, 3);
    end_load();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
